multi_counter_bank: RTL

Parametrised bank of NUM_CH independent WIDTH-bit counters, the next generation of the fixed three-channel 8-bit counter DUT driven by the HSE testbench. Each channel has its own enable, direction, wrap/saturate mode, synchronous load and programmable limit. Each channel also reports a registered terminal-count pulse and a sticky overflow flag, so Lua-side scoreboards can check events without decoding raw counts.

---
 rtl/multi_counter_bank.sv | 92 +++++++++
 1 files changed

// File: rtl/multi_counter_bank.sv
// ============================================================================
// Module      : multi_counter_bank
// Description : Bank of NUM_CH independent WIDTH-bit up/down counters with
//               wrap/saturate modes, loadable counts, programmable limits,
//               registered terminal-count pulses and sticky overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_counter_bank #(
  parameter int                NUM_CH    = 3,
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  LIMIT_RST = {WIDTH{1'b1}},
  parameter int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       sat,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic                    lim_we,
  input  logic [CH_W-1:0]         lim_ch,
  input  logic [WIDTH-1:0]        lim_val,
  input  logic [NUM_CH-1:0]       clr_ovf,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Matching on the exact index means out-of-range lim_ch selects no channel.
    localparam logic [CH_W-1:0] c_idx = CH_W'(i);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_lim;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_at_term;
    logic             w_event;
    logic             w_lim_wr;

    always_comb begin
      w_at_term = dir[i] ? (r_cnt >= r_lim) : (r_cnt == '0);
      w_event   = en[i] & ~load[i] & w_at_term;
      w_lim_wr  = lim_we & (lim_ch == c_idx);
      w_cnt_nxt = r_cnt;
      if (load[i]) begin
        w_cnt_nxt = load_val[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        if (w_at_term) begin
          if (!sat[i]) begin
            w_cnt_nxt = dir[i] ? '0 : r_lim;
          end
        end else begin
          w_cnt_nxt = dir[i] ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
        end
      end
    end

    // The step above reads the old r_lim, so a same-edge limit write only
    // affects later steps.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
        r_lim <= LIMIT_RST;
        r_tc  <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_tc  <= w_event;
        if (w_event) begin
          r_ovf <= 1'b1;
        end else if (clr_ovf[i]) begin
          r_ovf <= 1'b0;
        end
        if (w_lim_wr) begin
          r_lim <= lim_val;
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = r_cnt;
    assign tc[i]                   = r_tc;
    assign ovf[i]                  = r_ovf;
  end

endmodule

`default_nettype wire
